// File: rtl/route_demux2.sv
// route_demux2: routes each upstream word into one of two single-entry output channels.
// Each channel has a holding register with same-cycle drain/refill and a saturating delivery counter.
module route_demux2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_select_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out0_valid_o,
    output logic                  out1_valid_o,
    input  logic                  out0_ready_i,
    input  logic                  out1_ready_i,
    output logic [DATA_WIDTH-1:0] out0_data_o,
    output logic [DATA_WIDTH-1:0] out1_data_o,
    output logic [15:0]           xfer0_count_o,
    output logic [15:0]           xfer1_count_o
);
    logic                  v0, v1;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic [15:0]           cnt0, cnt1;
    logic                  drain0, drain1, load0, load1;

    assign drain0 = v0 & out0_ready_i;
    assign drain1 = v1 & out1_ready_i;
    // a channel can accept while its current word leaves on the same edge
    assign in_ready_o = reset_ni & (in_select_i ? (~v1 | drain1) : (~v0 | drain0));
    assign load0 = in_valid_i & in_ready_o & ~in_select_i;
    assign load1 = in_valid_i & in_ready_o & in_select_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            d0   <= '0;
            d1   <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            v0   <= load0 | (v0 & ~drain0);
            v1   <= load1 | (v1 & ~drain1);
            d0   <= load0 ? in_data_i : d0;
            d1   <= load1 ? in_data_i : d1;
            cnt0 <= cnt0 + 16'(drain0 & ~&cnt0);
            cnt1 <= cnt1 + 16'(drain1 & ~&cnt1);
        end
    end

    assign out0_valid_o  = v0;
    assign out1_valid_o  = v1;
    assign out0_data_o   = v0 ? d0 : '0;
    assign out1_data_o   = v1 ? d1 : '0;
    assign xfer0_count_o = cnt0;
    assign xfer1_count_o = cnt1;
endmodule

// File: doc/route_demux2.md
ROUTE_DEMUX2 -- requirements
Module: route_demux2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid_i, input, 1 bit: upstream word present.
REQ-005 The block SHALL have port in_ready_o, output, 1 bit: block accepts the upstream word this cycle.
REQ-006 The block SHALL have port in_select_i, input, 1 bit: destination channel, 0 or 1.
REQ-007 The block SHALL have port in_data_i, input, DATA_WIDTH bits: upstream payload.
REQ-008 The block SHALL have ports out0_valid_o and out1_valid_o, output, 1 bit each: channel holds a word.
REQ-009 The block SHALL have ports out0_ready_i and out1_ready_i, input, 1 bit each: downstream consumer takes the word.
REQ-010 The block SHALL have ports out0_data_o and out1_data_o, output, DATA_WIDTH bits each: channel payload.
REQ-011 The block SHALL have ports xfer0_count_o and xfer1_count_o, output, 16 bits each: per-channel delivered-word count.

Function
REQ-012 Each channel n SHALL contain one holding register (valid flag plus DATA_WIDTH data).
REQ-013 An upstream handshake SHALL occur when in_valid_i and in_ready_o are both 1 on a clock edge.
REQ-014 in_ready_o SHALL be combinational: 1 when the channel named by in_select_i is empty or is draining this cycle (outN_valid_o and outN_ready_i both 1); otherwise 0.
REQ-015 in_ready_o SHALL NOT depend on in_valid_i.
REQ-016 On an upstream handshake, in_data_i SHALL be loaded into the selected channel register, and its valid flag set, on the same edge; latency from handshake to outN_valid_o is 1 cycle.
REQ-017 A downstream handshake on channel n SHALL occur when outN_valid_o and outN_ready_i are both 1; the valid flag SHALL clear on that edge unless refilled.
REQ-018 Simultaneous drain and refill of the same channel SHALL leave valid at 1 and load the new word, giving full throughput of one word per cycle per channel.
REQ-019 The two channels SHALL operate independently; a stalled channel SHALL NOT block words routed to the other channel.
REQ-020 outN_data_o SHALL be all zeros whenever outN_valid_o is 0, and the held word otherwise.
REQ-021 A held word SHALL remain stable on outN_data_o until its downstream handshake.
REQ-022 xferN_count_o SHALL increment by 1 on each channel-n downstream handshake.
REQ-023 xferN_count_o SHALL saturate at 16'hFFFF and never wrap.
REQ-024 Behaviour SHALL be defined when in_valid_i is 0: no state change other than drains.

Reset
REQ-025 While reset_ni is 0, out0_valid_o and out1_valid_o SHALL be 0, out0_data_o and out1_data_o SHALL be 0, and both counters SHALL be 0, immediately and without a clock edge.
REQ-026 While reset_ni is 0, in_ready_o SHALL be 0.
REQ-027 Assertion of reset mid-operation SHALL discard any held words.
REQ-028 Normal operation SHALL resume on the first rising edge after reset_ni returns to 1.

Verification
REQ-029 The bench SHALL cover reset: reset_ni=0 -> in_ready_o=0, all valid outputs 0, all data outputs 0, all counts 0, checked before any clock edge.
REQ-030 The bench SHALL cover a single route: in_select_i=1, in_data_i=32'hDEADBEEF, out1_ready_i=1 -> next cycle out1_valid_o=1 with out1_data_o=32'hDEADBEEF, out0_data_o=0; following edge xfer1_count_o=1.
REQ-031 The bench SHALL cover backpressure: out0_ready_i=0, two words sent to channel 0 -> first accepted; in_ready_o=0 for the second until out0_ready_i=1; data order is preserved.
REQ-032 The bench SHALL cover independence: channel 0 full and stalled, in_select_i=1 -> in_ready_o=1, and the word reaches out1 one cycle later.
REQ-033 The bench SHALL cover streaming: out0_ready_i held 1, 8 back-to-back words to channel 0 -> in_ready_o stays 1, one word is delivered per cycle, and xfer0_count_o=8.
REQ-034 The bench SHALL cover saturation and mid-operation reset: counter forced to 16'hFFFE plus 3 transfers -> 16'hFFFF; reset_ni pulsed low while a word is held -> valid 0, data 0, counts 0.
